eth_pcs_block_sync: RTL and testbench
=====================================

ETH_PCS_BLOCK_SYNC -- requirements
Module: eth_pcs_block_sync

Interface
REQ-001 SHALL have parameter SH_CNT_MAX, default 64, headers per test window.
REQ-002 SHALL have parameter SH_INVALID_MAX, default 16, invalid headers per window that force loss of lock.
REQ-003 SHALL have parameter SLIP_WAIT, default 4, header events ignored after a slip before testing resumes.
REQ-004 SHALL have port i_clk  input  1  single clock; one clock; all state on its rising edge.
REQ-005 SHALL have port i_reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port i_clk_en  input  1  clock enable; state advances only when high.
REQ-007 SHALL have port i_hdr_valid  input  1  i_hdr carries a 66b block sync header this cycle.
REQ-008 SHALL have port i_hdr  input  2  sync header in transmission order.
REQ-009 SHALL have port o_slip  output  1  one-cycle pulse telling the RX gearbox to shift alignment by one bit.
REQ-010 SHALL have port o_block_lock  output  1  block lock status for the descrambler/decoder.
REQ-011 SHALL have port o_hdr_err  output  1  one-cycle pulse per invalid header while not in SLIP.

Function
REQ-012 SHALL define a header event as i_clk_en & i_hdr_valid; all other cycles SHALL leave counters and state unchanged, except LOCK_INIT->RESET_CNT and RESET_CNT->TEST_SH, which need only i_clk_en.
REQ-013 SHALL classify a header as valid iff i_hdr is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
REQ-014 SHALL implement states LOCK_INIT, RESET_CNT, TEST_SH and SLIP.
REQ-015 SHALL, in LOCK_INIT, hold o_block_lock=0 and go to RESET_CNT on the next enabled cycle.
REQ-016 SHALL, in RESET_CNT, clear sh_cnt (7 bits) and sh_invalid_cnt (5 bits) and go to TEST_SH on the next enabled cycle; header events in this cycle are not counted.
REQ-017 SHALL, in TEST_SH on each header event, increment sh_cnt, and on an invalid header also increment sh_invalid_cnt and pulse o_hdr_err the following cycle.
REQ-018 SHALL, on a valid header that makes sh_cnt==SH_CNT_MAX, go to RESET_CNT and set o_block_lock=1 if sh_invalid_cnt==0; otherwise go to RESET_CNT with lock unchanged.
REQ-019 SHALL, on an invalid header with o_block_lock=0, go to SLIP immediately regardless of counts.
REQ-020 SHALL, on an invalid header with o_block_lock=1 that makes sh_invalid_cnt==SH_INVALID_MAX, go to SLIP.
REQ-021 SHALL, on an invalid header with o_block_lock=1, sh_invalid_cnt<SH_INVALID_MAX and sh_cnt==SH_CNT_MAX, go to RESET_CNT with lock held at 1.
REQ-022 SHALL, on entering SLIP, clear o_block_lock and assert o_slip for exactly one cycle, the cycle after the triggering header.
REQ-023 SHALL, in SLIP, ignore SLIP_WAIT header events, with no counting and no o_hdr_err, then go to RESET_CNT.
REQ-024 SHALL have counters that never wrap; sh_cnt is bounded by SH_CNT_MAX and sh_invalid_cnt by SH_INVALID_MAX.
REQ-025 SHALL drive all outputs from registers, so o_block_lock changes the cycle after the deciding header event.
REQ-026 SHALL drop o_slip and o_hdr_err when i_clk_en is low on the pulse cycle; they then stay low.

Reset
REQ-027 SHALL, on i_reset_n low, asynchronously force state LOCK_INIT, sh_cnt=0, sh_invalid_cnt=0, slip-wait count=0, o_block_lock=0, o_slip=0 and o_hdr_err=0.
REQ-028 SHALL, on reset mid-operation including during SLIP, discard all progress and restart from LOCK_INIT after release.

Verification
REQ-029 SHALL verify: reset, then 64 valid headers (alternating 01/10) -> o_block_lock=1 one cycle after the 64th header, o_slip never pulses.
REQ-030 SHALL verify: unlocked, 10 valid headers then one 2'b11 -> o_hdr_err and o_slip each pulse once, o_block_lock stays 0, the next 4 headers are ignored, then counting restarts.
REQ-031 SHALL verify: locked, 15 invalid headers spread within one 64-header window -> lock stays 1, 15 o_hdr_err pulses, no slip, next window with 0 invalid headers keeps lock.
REQ-032 SHALL verify: locked, 16 invalid headers in one window -> o_block_lock=0 and one o_slip pulse one cycle after the 16th.
REQ-033 SHALL verify: i_clk_en low for 20 cycles with i_hdr_valid=1 and i_hdr=2'b00 mid-window -> no count change, no pulses, no state change.
REQ-034 SHALL verify: i_reset_n asserted during SLIP and while locked -> all outputs 0 immediately (asynchronous), relock requires a full 64 valid headers.

Source files
------------

// File: rtl/eth_pcs_block_sync.sv
// 64b/66b block lock state machine.
// Watches the 2-bit sync header of each received block, declares block lock
// after a full window of clean headers, and asks the RX gearbox to slip one
// bit whenever alignment looks wrong.
module eth_pcs_block_sync #(
  parameter int SH_CNT_MAX     = 64,  // headers per test window
  parameter int SH_INVALID_MAX = 16,  // invalid headers per window that break lock
  parameter int SLIP_WAIT      = 4    // header events ignored after a slip (>= 1)
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_clk_en,
  input  logic       i_hdr_valid,
  input  logic [1:0] i_hdr,
  output logic       o_slip,
  output logic       o_block_lock,
  output logic       o_hdr_err
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT);

  typedef enum logic [1:0] {
    LOCK_INIT,
    RESET_CNT,
    TEST_SH,
    SLIP
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    sh_cnt, sh_cnt_n;
  logic [INV_W-1:0]    sh_invalid_cnt, sh_invalid_cnt_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_n;
  logic                lock_n, slip_n, hdr_err_n;

  logic hdr_event;
  logic hdr_ok;

  // A header only counts on an enabled cycle; 01 and 10 are the legal headers.
  assign hdr_event = i_clk_en & i_hdr_valid;
  assign hdr_ok    = (i_hdr == 2'b01) || (i_hdr == 2'b10);

  // Next-state, counter and output decisions for the lock state machine.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_n          = state;
    sh_cnt_n         = sh_cnt;
    sh_invalid_cnt_n = sh_invalid_cnt;
    wait_cnt_n       = wait_cnt;
    lock_n           = o_block_lock;
    slip_n           = 1'b0;
    hdr_err_n        = 1'b0;

    unique case (state)
      LOCK_INIT: begin
        lock_n = 1'b0;
        if (i_clk_en) state_n = RESET_CNT;
      end

      RESET_CNT: begin
        // Headers arriving in this cycle are deliberately not counted.
        if (i_clk_en) begin
          sh_cnt_n         = '0;
          sh_invalid_cnt_n = '0;
          wait_cnt_n       = '0;
          state_n          = TEST_SH;
        end
      end

      TEST_SH: begin
        if (hdr_event) begin
          sh_cnt_n = sh_cnt + 1'b1;
          if (hdr_ok) begin
            // Window complete: only a spotless window grants lock.
            if (sh_cnt_n == CNT_LAST) begin
              state_n = RESET_CNT;
              if (sh_invalid_cnt == '0) lock_n = 1'b1;
            end
          end else begin
            hdr_err_n        = 1'b1;
            sh_invalid_cnt_n = sh_invalid_cnt + 1'b1;
            // Unlocked: any bad header means wrong alignment. Locked: only a
            // burst of SH_INVALID_MAX in one window does. Slip wins over the
            // window ending on the same header.
            if (!o_block_lock || sh_invalid_cnt_n == INV_LAST) begin
              state_n    = SLIP;
              lock_n     = 1'b0;
              slip_n     = 1'b1;
              wait_cnt_n = '0;
            end else if (sh_cnt_n == CNT_LAST) begin
              state_n = RESET_CNT;
            end
          end
        end
      end

      SLIP: begin
        // Give the gearbox time to settle before judging headers again.
        if (hdr_event) begin
          wait_cnt_n = wait_cnt + 1'b1;
          if (wait_cnt_n == WAIT_LAST) begin
            state_n    = RESET_CNT;
            wait_cnt_n = '0;
          end
        end
      end

      default: state_n = LOCK_INIT;
    endcase
  end

  // State, counters and registered outputs; pulses clear on any cycle without a trigger.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= LOCK_INIT;
      sh_cnt         <= '0;
      sh_invalid_cnt <= '0;
      wait_cnt       <= '0;
      o_block_lock   <= 1'b0;
      o_slip         <= 1'b0;
      o_hdr_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed before this edge, independent of statement order.
      state          <= state_n;
      sh_cnt         <= sh_cnt_n;
      sh_invalid_cnt <= sh_invalid_cnt_n;
      wait_cnt       <= wait_cnt_n;
      o_block_lock   <= lock_n;
      o_slip         <= slip_n;
      o_hdr_err      <= hdr_err_n;
    end
  end

endmodule

// File: tb/tb_eth_pcs_block_sync.sv
// Self-checking bench for eth_pcs_block_sync: a directed vector table, hand
// sequences for lock/slip/enable/reset corners, and a randomized run checked
// against a behavioural model of the block-lock rules.
module tb_eth_pcs_block_sync;

  localparam int CNT_MAX = 64;
  localparam int INV_MAX = 16;
  localparam int WAIT_N  = 4;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_clk_en;
  logic       i_hdr_valid;
  logic [1:0] i_hdr;
  logic       o_slip;
  logic       o_block_lock;
  logic       o_hdr_err;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: tracks pending "dead" enabled cycles before testing,
  // headers still to be ignored after a slip, and per-window tallies.
  bit m_lock;
  int m_skip;
  int m_ignore;
  int m_seen;
  int m_bad;
  bit m_slip;
  bit m_err;

  int slip_seen;
  int err_seen;

  typedef struct {
    logic       en;
    logic       valid;
    logic [1:0] hdr;
    logic [2:0] exp;  // {o_block_lock, o_slip, o_hdr_err}
  } vec_t;

  vec_t vecs[$];

  eth_pcs_block_sync #(
    .SH_CNT_MAX    (CNT_MAX),
    .SH_INVALID_MAX(INV_MAX),
    .SLIP_WAIT     (WAIT_N)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_clk_en    (i_clk_en),
    .i_hdr_valid (i_hdr_valid),
    .i_hdr       (i_hdr),
    .o_slip      (o_slip),
    .o_block_lock(o_block_lock),
    .o_hdr_err   (o_hdr_err)
  );

  // Free-running clock, 10 time units per period.
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] alt(input int i);
    return i[0] ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    m_lock   = 1'b0;
    m_skip   = 2;  // one enabled cycle leaving init, one clearing counters
    m_ignore = 0;
    m_seen   = 0;
    m_bad    = 0;
    m_slip   = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit valid, input logic [1:0] hdr);
    bit good;
    m_slip = 1'b0;
    m_err  = 1'b0;
    if (!en) return;
    if (m_skip > 0) begin
      m_skip--;
      m_seen = 0;
      m_bad  = 0;
    end else if (m_ignore > 0) begin
      if (valid) begin
        m_ignore--;
        if (m_ignore == 0) m_skip = 1;
      end
    end else if (valid) begin
      good = (hdr == 2'b01) || (hdr == 2'b10);
      m_seen++;
      if (!good) begin
        m_bad++;
        m_err = 1'b1;
      end
      if (!good && (!m_lock || m_bad == INV_MAX)) begin
        m_lock   = 1'b0;
        m_slip   = 1'b1;
        m_ignore = WAIT_N;
      end else if (m_seen == CNT_MAX) begin
        if (m_bad == 0) m_lock = 1'b1;
        m_skip = 1;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, compare just after the edge.
  task automatic step(input bit en, input bit valid, input logic [1:0] hdr, input string tag);
    i_clk_en    = en;
    i_hdr_valid = valid;
    i_hdr       = hdr;
    @(posedge i_clk);
    model_step(en, valid, hdr);
    #1;
    check({"model:", tag}, {29'd0, o_block_lock, o_slip, o_hdr_err}, {29'd0, m_lock, m_slip, m_err});
    if (o_slip === 1'b1) slip_seen++;
    if (o_hdr_err === 1'b1) err_seen++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 2'b00, "idle");
  endtask

  task automatic good_hdrs(input int n, input string tag);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, alt(k), tag);
  endtask

  task automatic do_reset();
    i_reset_n   = 1'b0;
    i_clk_en    = 1'b0;
    i_hdr_valid = 1'b0;
    i_hdr       = 2'b00;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic async_reset(input string tag);
    #3;
    i_reset_n = 1'b0;
    #1;
    check({tag, "_outs"}, {29'd0, o_block_lock, o_slip, o_hdr_err}, 32'd0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  task automatic push(input logic en, input logic valid, input logic [1:0] hdr, input logic [2:0] exp);
    vec_t v;
    v.en    = en;
    v.valid = valid;
    v.hdr   = hdr;
    v.exp   = exp;
    vecs.push_back(v);
  endtask

  initial begin
    int pulses;
    int lock_low;
    int rate;
    bit en;
    bit valid;
    logic [1:0] hdr;
    int rates[4] = '{0, 10, 50, 300};

    // Reset state.
    i_reset_n   = 1'b0;
    i_clk_en    = 1'b0;
    i_hdr_valid = 1'b0;
    i_hdr       = 2'b00;
    #1;
    check("reset_lock", {31'd0, o_block_lock}, 32'd0);
    check("reset_slip", {31'd0, o_slip}, 32'd0);
    check("reset_err",  {31'd0, o_hdr_err}, 32'd0);

    // Unlocked slip scenario as a vector table.
    push(1, 0, 2'b00, 3'b000);
    push(1, 0, 2'b00, 3'b000);
    for (int i = 0; i < 10; i++) push(1, 1, alt(i), 3'b000);
    push(1, 1, 2'b11, 3'b011);
    for (int i = 0; i < WAIT_N; i++) push(1, 1, alt(i), 3'b000);
    push(1, 1, 2'b00, 3'b000);  // counter-clear cycle: header not judged
    for (int i = 0; i < CNT_MAX - 1; i++) push(1, 1, alt(i), 3'b000);
    push(1, 1, alt(CNT_MAX - 1), 3'b100);
    push(1, 0, 2'b00, 3'b100);
    push(1, 0, 2'b00, 3'b100);

    do_reset();
    slip_seen = 0;
    err_seen  = 0;
    foreach (vecs[i]) begin
      i_clk_en    = vecs[i].en;
      i_hdr_valid = vecs[i].valid;
      i_hdr       = vecs[i].hdr;
      @(posedge i_clk);
      #1;
      check($sformatf("vec[%0d]", i), {29'd0, o_block_lock, o_slip, o_hdr_err}, {29'd0, vecs[i].exp});
      if (o_slip === 1'b1) slip_seen++;
      if (o_hdr_err === 1'b1) err_seen++;
    end
    check("vec_slip_pulses", slip_seen, 1);
    check("vec_err_pulses",  err_seen,  1);

    // First lock after 64 clean headers.
    do_reset();
    slip_seen = 0;
    idle(2);
    good_hdrs(CNT_MAX - 1, "ramp");
    check("lock_before_64th", {31'd0, o_block_lock}, 32'd0);
    step(1'b1, 1'b1, alt(CNT_MAX - 1), "hdr_64");
    check("lock_after_64th", {31'd0, o_block_lock}, 32'd1);
    check("ramp_no_slip", slip_seen, 0);

    // Locked: 15 bad headers in one window keep lock.
    idle(1);
    err_seen  = 0;
    lock_low  = 0;
    for (int i = 0; i < CNT_MAX; i++) begin
      hdr = (i % 4 == 1 && i < 60) ? 2'b11 : alt(i);
      step(1'b1, 1'b1, hdr, "win15");
      if (o_block_lock !== 1'b1) lock_low++;
    end
    check("win15_err_pulses", err_seen, 15);
    check("win15_no_slip", slip_seen, 0);
    check("win15_lock_low_cycles", lock_low, 0);
    idle(1);
    good_hdrs(CNT_MAX, "clean_win");
    check("clean_win_lock", {31'd0, o_block_lock}, 32'd1);
    check("clean_win_errs", err_seen, 15);

    // Locked: the 16th bad header in a window drops lock and slips.
    idle(1);
    for (int i = 0; i <= 45; i++) begin
      hdr = (i % 3 == 0) ? 2'b00 : alt(i);
      if (i == 45) check("lock_before_16th", {31'd0, o_block_lock}, 32'd1);
      step(1'b1, 1'b1, hdr, "win16");
    end
    check("win16_slip", {31'd0, o_slip}, 32'd1);
    check("win16_lock", {31'd0, o_block_lock}, 32'd0);
    good_hdrs(6, "after16");
    check("win16_slip_pulses", slip_seen, 1);

    // Clock enable low mid-window with bad headers on the bus.
    do_reset();
    slip_seen = 0;
    err_seen  = 0;
    idle(2);
    good_hdrs(30, "pre_gap");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 2'b00, "en_low");
    good_hdrs(CNT_MAX - 31, "post_gap");
    check("gap_lock_before_64th", {31'd0, o_block_lock}, 32'd0);
    step(1'b1, 1'b1, 2'b01, "gap_hdr_64");
    check("gap_lock_after_64th", {31'd0, o_block_lock}, 32'd1);
    check("gap_pulses", slip_seen + err_seen, 0);

    // Pulses do not stretch when the enable drops on the pulse cycle.
    do_reset();
    idle(2);
    good_hdrs(5, "pre_bad");
    step(1'b1, 1'b1, 2'b00, "bad_hdr");
    check("pulse_slip_set", {31'd0, o_slip}, 32'd1);
    check("pulse_err_set",  {31'd0, o_hdr_err}, 32'd1);
    step(1'b0, 1'b0, 2'b00, "en_off1");
    check("pulse_dropped", {30'd0, o_slip, o_hdr_err}, 32'd0);
    step(1'b0, 1'b0, 2'b00, "en_off2");
    check("pulse_stays_low", {30'd0, o_slip, o_hdr_err}, 32'd0);

    // Asynchronous reset during SLIP, then while locked; relock needs 64 headers.
    do_reset();
    idle(2);
    good_hdrs(3, "pre_slip");
    step(1'b1, 1'b1, 2'b11, "enter_slip");
    async_reset("rst_in_slip");
    idle(2);
    good_hdrs(CNT_MAX, "relock1");
    check("relock1_lock", {31'd0, o_block_lock}, 32'd1);
    async_reset("rst_locked");
    idle(2);
    good_hdrs(CNT_MAX - 1, "relock2");
    check("relock2_before_64th", {31'd0, o_block_lock}, 32'd0);
    step(1'b1, 1'b1, 2'b10, "relock2_64");
    check("relock2_after_64th", {31'd0, o_block_lock}, 32'd1);

    // Randomized traffic with varying error density against the model.
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      if (seg % 3 == 2) do_reset();
      rate = rates[seg % 4];
      for (int c = 0; c < 400; c++) begin
        en    = ($urandom_range(0, 9) != 0);
        valid = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 999) < rate)
          hdr = $urandom_range(0, 1) ? 2'b11 : 2'b00;
        else
          hdr = $urandom_range(0, 1) ? 2'b01 : 2'b10;
        step(en, valid, hdr, "random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
